// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner
// Turns the raw, bouncy pedestrian push-button into a clean request for the
// traffic-light controller. The button is synchronised, debounced and
// converted into one single-cycle pdst pulse per accepted press. A lockout
// window after each release ignores the button. A WAIT lamp is lit when a
// request is issued and stays lit until the controller shows RED.
//
// Optional feature macro: PRESS_COUNT_EN adds the press_count output, a
// saturating count of presses that actually emitted pdst.
//
// Ports:
//   clk         system clock (shared with the traffic-light controller)
//   rst         synchronous, active-high reset
//   btn_raw     asynchronous pedestrian button, active high
//   light       controller lamps, one-hot {R,Y,G}; 3'b100 = RED
//   pdst        registered single-cycle request pulse
//   wait_lamp   registered pedestrian WAIT indicator
//   busy        high whenever the FSM is not IDLE (combinational from state)
//   press_count (PRESS_COUNT_EN only) saturating count of emitted requests
module ped_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned LOCKOUT_CYCLES  = 50,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [2:0] light,
  output logic       pdst,
  output logic       wait_lamp,
  output logic       busy
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LIGHT_RED = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  logic             s1_r;
  logic             btn_s_r;
  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             accept_s;
  logic             red_s;
  logic             pdst_r;
  logic             wait_lamp_r;

  assign red_s     = (light == LIGHT_RED);
  assign pdst      = pdst_r;
  assign wait_lamp = wait_lamp_r;
  assign busy      = (state_r != ST_IDLE);

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r    <= 1'b0;
      btn_s_r <= 1'b0;
    end else begin
      s1_r    <= btn_raw;
      btn_s_r <= s1_r;
    end
  end

  // FSM state and shared debounce/lockout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; accept_s marks the edge on which a press is accepted.
  // The terminal compares stop the counter, so it never wraps.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (btn_s_r) begin
          state_s = ST_DEBOUNCE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (!btn_s_r) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else if (cnt_r == DEB_LAST) begin
          state_s  = ST_HELD;
          cnt_s    = '0;
          accept_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        // A held button never re-triggers; only the release moves on.
        if (!btn_s_r) begin
          state_s = ST_LOCKOUT;
          cnt_s   = '0;
        end else begin
          state_s = ST_HELD;
        end
      end
      ST_LOCKOUT: begin
        // The button is deliberately ignored for the whole window.
        if (cnt_r == LOCK_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Request pulse and WAIT lamp. A press accepted during RED is consumed
  // but emits nothing, so lamp set and clear can never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      pdst_r      <= 1'b0;
      wait_lamp_r <= 1'b0;
    end else begin
      pdst_r <= accept_s && !red_s;
      if (red_s) begin
        wait_lamp_r <= 1'b0;
      end else if (accept_s) begin
        wait_lamp_r <= 1'b1;
      end else begin
        wait_lamp_r <= wait_lamp_r;
      end
    end
  end

`ifdef PRESS_COUNT_EN
  logic [7:0] press_count_r;

  assign press_count = press_count_r;

  // Saturating count of presses that emitted a request pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_count_r <= 8'h00;
    end else if (accept_s && !red_s && (press_count_r != 8'hFF)) begin
      press_count_r <= press_count_r + 8'h01;
    end else begin
      press_count_r <= press_count_r;
    end
  end
`endif

endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
- Upstream stage of the traffic-light controller. Conditions the raw pedestrian push-button into the clean `pdst` request that the controller latches.
- Synchronises the asynchronous button, debounces it, and emits exactly one single-cycle pulse per accepted press.
- Enforces a lockout after each release.
- Drives a "WAIT" indicator lamp until the controller shows RED.

Parameters:
- DEBOUNCE_CYCLES, 20, clk cycles the synchronised button must stay high before a press is accepted (legal range 1 to 2**CNT_W-1).
- LOCKOUT_CYCLES, 50, clk cycles after release during which the button is ignored (legal range 1 to 2**CNT_W-1).
- CNT_W, 16, width of the shared debounce/lockout counter.

Ports:
- clk  input  1  system clock (same clk as the traffic-light controller).
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous, bouncy pedestrian button, active high.
- light  input  3  controller lamp output, one-hot {R,Y,G}; 3'b100 = RED.
- pdst  output  1  registered request pulse to the controller, high for exactly 1 cycle per accepted press.
- wait_lamp  output  1  registered pedestrian "WAIT" indicator.
- busy  output  1  high whenever the FSM is not in IDLE.

Interface rule: one clock, clk; reset is synchronous and active-high, named rst.

Behaviour:
- Reset (sampled at the clk edge, synchronous):
  - sync flops, counter, pdst and wait_lamp all go to 0; FSM goes to IDLE.
  - A reset mid-operation aborts any in-flight debounce or lockout; a pdst pulse in flight is forced low on that edge.
- Synchroniser: 2-flop chain btn_raw -> s1 -> btn_s. The FSM only ever uses btn_s.
- FSM states: IDLE, DEBOUNCE, HELD, LOCKOUT.
  - IDLE: if btn_s=1, go to DEBOUNCE with cnt=0.
  - DEBOUNCE:
    - if btn_s=0, go to IDLE (bounce rejected, no output).
    - else if cnt==DEBOUNCE_CYCLES-1, go to HELD (press accepted).
    - else cnt++.
  - HELD: stay until btn_s=0, then go to LOCKOUT with cnt=0. A held button never produces a second pulse.
  - LOCKOUT:
    - if cnt==LOCKOUT_CYCLES-1, go to IDLE; else cnt++.
    - btn_s is ignored, including any presses during lockout.
- Latency: btn_raw rising before edge 1 and held steady gives btn_s=1 after edge 2, DEBOUNCE after edge 3, and HELD plus the pdst pulse after edge 3+DEBOUNCE_CYCLES.
- pdst:
  - Set for the cycle after the DEBOUNCE->HELD edge, then cleared on the next edge.
  - Suppressed if light==3'b100 on the accepting edge, because pedestrians already have the crossing. The press is still consumed (FSM enters HELD).
- wait_lamp:
  - Set on the same edge pdst is set.
  - Cleared on any edge where light==3'b100.
  - Set and clear cannot coincide, because pdst is suppressed during RED.
  - Once set, stays set across further presses until RED.
- busy is combinational from state: (state != IDLE).
- Counter: unsigned, CNT_W bits. It never wraps, because the terminal compares stop it at the programmed value.
- Illegal or unused state encodings return to IDLE on the next edge with cnt=0.

Optional Feature:
- Macro: PRESS_COUNT_EN.
- When defined:
  - Adds output port press_count [7:0]: a count of accepted presses that actually emitted pdst.
  - Saturates at 8'hFF; reset to 0 by rst.
  - Suppressed (RED-time) presses are not counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Clean press: rst, light=3'b001, btn_raw=1 held 40 cycles -> pdst exactly one 1-cycle pulse, 23 edges after btn_raw rise; wait_lamp=1 from the same cycle; busy=1 from edge 3.
- Bounce rejection: btn_raw toggles high 5 cycles / low 3 cycles, repeated 10 times, light=GREEN -> pdst never asserts; FSM returns to IDLE after each low.
- Lockout: press (30 cycles), release, press again 10 cycles after release -> no second pulse. Press again 60 cycles after release (held 30) -> second pulse; wait_lamp stays 1.
- RED suppression: light=3'b100 during the whole press -> pdst=0, wait_lamp=0, FSM still passes through HELD/LOCKOUT. Next: wait_lamp set in GREEN clears on the first edge light==3'b100.
- Reset mid-operation: assert rst for 1 cycle while in DEBOUNCE (cnt=10) and again on the pdst-high cycle -> next cycle pdst=0, wait_lamp=0, busy=0, state IDLE.
- PRESS_COUNT_EN build: 3 valid presses plus 1 RED-time press -> press_count=3. 300 forced valid presses -> press_count=8'hFF.
